sprite_line_sched: RTL

Per-line sprite scheduler that shares a small pool of hardware sprite engines among a larger table of sprite positions. During each active line it scans the sprite table, selects up to SLOTS sprites that intersect the *next* line, and commits the selection on the following `line` pulse. The committed slot outputs drive the `sprx`/`spry` inputs of the per-slot sprite engines in the same clock domain.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_line_sched_if.sv | 34 +++
 rtl/sprite_table.sv | 34 +++
 rtl/sprite_line_sched.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and defaults for the sprite line scheduler
package sprite_pkg;
  localparam int DEF_CORDW      = 16;
  localparam int DEF_SPR_CNT    = 8;
  localparam int DEF_SLOTS      = 4;
  localparam int DEF_SPR_HEIGHT = 8;
  localparam int DEF_IDW        = $clog2(DEF_SPR_CNT);

  typedef struct packed {
    logic                        en;
    logic signed [DEF_CORDW-1:0] x;
    logic signed [DEF_CORDW-1:0] y;
  } spr_entry_t;

  typedef struct packed {
    logic                        valid;
    logic [DEF_IDW-1:0]          id;
    logic signed [DEF_CORDW-1:0] x;
    logic signed [DEF_CORDW-1:0] y;
  } slot_t;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;
endpackage

// File: rtl/sprite_line_sched_if.sv
// rtl/sprite_line_sched_if.sv - line/table inputs and committed slot outputs
interface sprite_line_sched_if
  import sprite_pkg::*;
#(
  parameter int CORDW   = DEF_CORDW,
  parameter int SPR_CNT = DEF_SPR_CNT,
  parameter int SLOTS   = DEF_SLOTS,
  parameter int IDW     = $clog2(SPR_CNT)
);
  logic                      line;
  logic signed [CORDW-1:0]   sy;
  logic                      tbl_we;
  logic [IDW-1:0]            tbl_addr;
  logic                      tbl_en;
  logic signed [CORDW-1:0]   tbl_x;
  logic signed [CORDW-1:0]   tbl_y;
  logic [SLOTS-1:0]          slot_valid;
  logic [SLOTS*IDW-1:0]      slot_id;
  logic [SLOTS*CORDW-1:0]    slot_x;
  logic [SLOTS*CORDW-1:0]    slot_y;
  logic                      ovf;
  logic                      miss;
  logic                      busy;

  modport master (
    output line, sy, tbl_we, tbl_addr, tbl_en, tbl_x, tbl_y,
    input  slot_valid, slot_id, slot_x, slot_y, ovf, miss, busy
  );

  modport slave (
    input  line, sy, tbl_we, tbl_addr, tbl_en, tbl_x, tbl_y,
    output slot_valid, slot_id, slot_x, slot_y, ovf, miss, busy
  );
endinterface

// File: rtl/sprite_table.sv
// rtl/sprite_table.sv - sprite position register file, sync write, comb read
module sprite_table
  import sprite_pkg::*;
#(
  parameter int SPR_CNT = DEF_SPR_CNT,
  parameter int IDW     = $clog2(SPR_CNT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [IDW-1:0] waddr,
  input  spr_entry_t     wdata,
  input  logic [IDW-1:0] raddr,
  output spr_entry_t     rdata
);
  spr_entry_t mem_q [SPR_CNT];
  spr_entry_t mem_d [SPR_CNT];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SPR_CNT; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read sees the pre-write contents, so a same-cycle write never affects the scan.
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sprite_line_sched.sv
// rtl/sprite_line_sched.sv - scans the sprite table for the next line and
// commits up to SLOTS hits to the sprite engines on each line pulse
module sprite_line_sched
  import sprite_pkg::*;
#(
  parameter int CORDW      = DEF_CORDW,
  parameter int SPR_CNT    = DEF_SPR_CNT,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int SPR_HEIGHT = DEF_SPR_HEIGHT,
  parameter int IDW        = $clog2(SPR_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  sprite_line_sched_if.slave bus
);
  localparam int FCW = $clog2(SLOTS + 1);

  state_t                  state_q, state_d;
  logic [IDW-1:0]          idx_q, idx_d;
  logic signed [CORDW-1:0] ny_q, ny_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  slot_t                   shadow_q [SLOTS];
  slot_t                   shadow_d [SLOTS];
  logic                    sovf_q, sovf_d;
  slot_t                   out_q [SLOTS];
  slot_t                   out_d [SLOTS];
  logic                    ovf_q, ovf_d;
  logic                    miss_q, miss_d;

  spr_entry_t              wr_ent, rd_ent;
  logic [CORDW:0]          dy;
  logic                    hit;

  assign wr_ent = '{en: bus.tbl_en, x: bus.tbl_x, y: bus.tbl_y};

  sprite_table #(.SPR_CNT(SPR_CNT), .IDW(IDW)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.tbl_we),
    .waddr (bus.tbl_addr),
    .wdata (wr_ent),
    .raddr (idx_q),
    .rdata (rd_ent)
  );

  // One extra bit keeps ny - y from wrapping near the coordinate extremes.
  assign dy  = {ny_q[CORDW-1], ny_q} - {rd_ent.y[CORDW-1], rd_ent.y};
  assign hit = rd_ent.en && !dy[CORDW] && (dy[CORDW-1:0] < CORDW'(SPR_HEIGHT));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ny_d     = ny_q;
    fcnt_d   = fcnt_q;
    shadow_d = shadow_q;
    sovf_d   = sovf_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    miss_d   = miss_q;
    if (bus.line) begin
      out_d   = shadow_q;
      ovf_d   = sovf_q;
      miss_d  = (state_q == ST_SCAN);
      for (int k = 0; k < SLOTS; k++) shadow_d[k] = '0;
      fcnt_d  = '0;
      sovf_d  = 1'b0;
      ny_d    = bus.sy + CORDW'(1);
      idx_d   = '0;
      state_d = ST_SCAN;
    end else if (state_q == ST_SCAN) begin
      if (hit) begin
        if (fcnt_q < FCW'(SLOTS)) begin
          for (int k = 0; k < SLOTS; k++) begin
            if (fcnt_q == FCW'(k)) begin
              shadow_d[k] = '{valid: 1'b1, id: idx_q, x: rd_ent.x, y: rd_ent.y};
            end
          end
          fcnt_d = fcnt_q + FCW'(1);
        end else begin
          sovf_d = 1'b1;
        end
      end
      if (idx_q == IDW'(SPR_CNT - 1)) state_d = ST_IDLE;
      else                            idx_d   = idx_q + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ny_q    <= '0;
      fcnt_q  <= '0;
      sovf_q  <= 1'b0;
      ovf_q   <= 1'b0;
      miss_q  <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        shadow_q[k] <= '0;
        out_q[k]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ny_q     <= ny_d;
      fcnt_q   <= fcnt_d;
      sovf_q   <= sovf_d;
      ovf_q    <= ovf_d;
      miss_q   <= miss_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  logic [SLOTS-1:0]       valid_o;
  logic [SLOTS*IDW-1:0]   id_o;
  logic [SLOTS*CORDW-1:0] x_o, y_o;

  always_comb begin
    valid_o = '0;
    id_o    = '0;
    x_o     = '0;
    y_o     = '0;
    for (int k = 0; k < SLOTS; k++) begin
      valid_o[k]             = out_q[k].valid;
      id_o[k*IDW +: IDW]     = out_q[k].id;
      x_o[k*CORDW +: CORDW]  = out_q[k].x;
      y_o[k*CORDW +: CORDW]  = out_q[k].y;
    end
  end

  assign bus.slot_valid = valid_o;
  assign bus.slot_id    = id_o;
  assign bus.slot_x     = x_o;
  assign bus.slot_y     = y_o;
  assign bus.ovf        = ovf_q;
  assign bus.miss       = miss_q;
  assign bus.busy       = (state_q == ST_SCAN);
endmodule
